// File: rtl/gfx_pkg.sv
// Shared graphics types: framebuffer geometry defaults, pixel/address
// typedefs and the write arbiter state encoding.
package gfx_pkg;

  localparam int FB_WIDTH      = 160;
  localparam int FB_HEIGHT     = 120;
  localparam int FB_DATA_WIDTH = 12;
  localparam int FB_ADDR_WIDTH = $clog2(FB_WIDTH * FB_HEIGHT);

  typedef logic [FB_ADDR_WIDTH-1:0] fb_addr_t;
  typedef logic [FB_DATA_WIDTH-1:0] fb_pixel_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // Index width that stays at least one bit for a single requester
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request scanning from ptr upward,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_priority_picker
  import gfx_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int IW = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      index
);

  always_comb begin : pick
    int j;
    j     = 0;
    found = 1'b0;
    index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        index = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin burst arbiter for the framebuffer write port.
// Optional FB_WRITE_CLIP_EN drops out-of-range beats and flags clip_err.
module fb_write_arbiter
  import gfx_pkg::*;
#(
  parameter int NUM_REQ           = 3,
  parameter int BUFFER_WIDTH      = FB_WIDTH,
  parameter int BUFFER_HEIGHT     = FB_HEIGHT,
  parameter int BUFFER_DATA_WIDTH = FB_DATA_WIDTH,
  parameter int BUFFER_ADDR_WIDTH =
    $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int MAX_BURST         = 16,
  localparam int IW = idx_width(NUM_REQ),
  localparam int AW = BUFFER_ADDR_WIDTH,
  localparam int DW = BUFFER_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  write_en,
  output logic [AW-1:0]         write_addr,
  output logic [DW-1:0]         write_data,
  output logic [IW-1:0]         grant_id,
  output logic                  busy,
  output logic                  clip_err
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt_ptr;
  logic [CW-1:0] cnt;
  logic          found;
  logic [IW-1:0] pick;
  logic          sel_valid;
  logic          sel_last;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          burst_end;
  logic          clip_hit;

  rr_priority_picker #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .found(found),
    .index(pick)
  );

  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_addr  = req_addr[int'(grant_id)*AW +: AW];
    sel_data  = req_data[int'(grant_id)*DW +: DW];
    burst_end = sel_last || (cnt + CW'(1) == CW'(MAX_BURST));
    nxt_ptr   = (grant_id == LAST_IDX) ? '0 : grant_id + IW'(1);
  end

`ifdef FB_WRITE_CLIP_EN
  localparam int PIXELS = BUFFER_WIDTH * BUFFER_HEIGHT;

  // Extra bit keeps the bound representable when it equals 2**AW
  assign clip_hit = {1'b0, sel_addr} >= (AW+1)'(PIXELS);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clip_err <= 1'b0;
    end else if (state == GRANT && sel_valid && clip_hit) begin
      clip_err <= 1'b1;
    end
  end
`else
  assign clip_hit = 1'b0;
  assign clip_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      req_ready  <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      write_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            grant_id  <= pick;
            cnt       <= '0;
            busy      <= 1'b1;
            req_ready <= NUM_REQ'(1) << pick;
          end
        end
        GRANT: begin
          if (!sel_valid) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= '0;
            ptr       <= nxt_ptr;
          end else begin
            cnt <= cnt + CW'(1);
            // Clipped beats complete the handshake but never reach the port
            if (!clip_hit) begin
              write_en   <= 1'b1;
              write_addr <= sel_addr;
              write_data <= sel_data;
            end
            if (burst_end) begin
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= '0;
              ptr       <= nxt_ptr;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: 3-requester and 1-requester
// instances driven by simple burst sources.
module tb_fb_write_arbiter;

  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;

  logic [2:0]    req_valid = '0;
  logic [2:0]    req_last = '0;
  logic [3*AW-1:0] req_addr = '0;
  logic [3*DW-1:0] req_data = '0;
  logic [2:0]    req_ready;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [1:0]    grant_id;
  logic          busy;
  logic          clip_err;

  logic          v1 = 1'b0;
  logic          l1 = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [DW-1:0] d1 = '0;
  logic          r1;
  logic          we1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic          g1;
  logic          busy1;
  logic          clip1;

  int beat[3];
  int lim[3];
  int last_at[3];
  int base[3];
  bit en[3];
  int b1 = 0;
  bit en1 = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .NUM_REQ  (3),
    .MAX_BURST(16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .clip_err  (clip_err)
  );

  fb_write_arbiter #(
    .NUM_REQ  (1),
    .MAX_BURST(16)
  ) dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (v1),
    .req_last  (l1),
    .req_addr  (a1),
    .req_data  (d1),
    .req_ready (r1),
    .write_en  (we1),
    .write_addr(wa1),
    .write_data(wd1),
    .grant_id  (g1),
    .busy      (busy1),
    .clip_err  (clip1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic src_reset();
    for (int i = 0; i < 3; i++) begin
      en[i]      = 1'b0;
      beat[i]    = 0;
      lim[i]     = 1000;
      last_at[i] = -1;
      base[i]    = i * 1000;
    end
    b1  = 0;
    en1 = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = en[i] && (beat[i] < lim[i]);
      req_last[i]  = (beat[i] == last_at[i]);
      req_addr[i*AW +: AW] = AW'(base[i] + beat[i]);
      req_data[i*DW +: DW] = DW'(i * 256 + beat[i]);
    end
    v1 = en1;
    l1 = b1[0];
    a1 = AW'(b1);
    d1 = DW'(b1);
  endtask

  // One clock: apply inputs, let sources advance on accepted beats
  task automatic step();
    logic [2:0] rdy;
    logic       rdy1;
    drive();
    rdy  = req_ready;
    rdy1 = r1;
    @(posedge clk);
    if (rstn) begin
      for (int i = 0; i < 3; i++)
        if (req_valid[i] && rdy[i]) beat[i]++;
      if (v1 && rdy1) b1++;
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    src_reset();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    src_reset();
    rstn = 1'b0;
    step();
    step();
    check("rst_we", write_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_addr", write_addr, 0);
    check("rst_data", write_data, 0);
    check("rst_clip", clip_err, 0);
    rstn = 1'b1;

    // single 4-beat burst from background
    en[0] = 1'b1; lim[0] = 4; last_at[0] = 3; base[0] = 0;
    step();
    check("t1_gid", grant_id, 0);
    check("t1_busy", busy, 1);
    check("t1_ready", req_ready, 3'b001);
    check("t1_bubble_we", write_en, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_we", write_en, 1);
      check("t1_addr", write_addr, k);
      check("t1_data", write_data, k);
    end
    check("t1_busy_end", busy, 0);
    step();
    check("t1_we_after", write_en, 0);
    check("t1_addr_hold", write_addr, 3);

    // three continuous requesters, max-length bursts
    do_reset();
    for (int i = 0; i < 3; i++) en[i] = 1'b1;
    for (int g = 0; g < 4; g++) begin
      step();
      check("t2_bubble_we", write_en, 0);
      check("t2_gid", grant_id, g % 3);
      check("t2_busy", busy, 1);
      for (int b = 0; b < 16; b++) begin
        step();
        check("t2_we", write_en, 1);
        check("t2_addr", write_addr, (g % 3) * 1000 + (g / 3) * 16 + b);
      end
      check("t2_release", busy, 0);
    end

    // requester 1 drops valid after 5 beats
    do_reset();
    en[1] = 1'b1; lim[1] = 5;
    step();
    check("t3_gid1", grant_id, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_we", write_en, 1);
      check("t3_addr", write_addr, 1000 + k);
    end
    en[0] = 1'b1; en[2] = 1'b1;
    step();
    check("t3_drop_we", write_en, 0);
    check("t3_drop_busy", busy, 0);
    step();
    check("t3_gid2", grant_id, 2);
    check("t3_busy2", busy, 1);
    step();
    check("t3_we2", write_en, 1);
    check("t3_addr2", write_addr, 2000);

    // reset in the middle of a burst
    do_reset();
    en[1] = 1'b1;
    step();
    check("t4_gid1", grant_id, 1);
    for (int k = 0; k < 7; k++) step();
    check("t4_pre_addr", write_addr, 1006);
    rstn = 1'b0;
    step();
    check("t4_we", write_en, 0);
    check("t4_ready", req_ready, 0);
    check("t4_busy", busy, 0);
    check("t4_gid", grant_id, 0);
    check("t4_addr", write_addr, 0);
    rstn = 1'b1;
    src_reset();
    for (int i = 0; i < 3; i++) en[i] = 1'b1;
    step();
    check("t4_regrant", grant_id, 0);
    check("t4_regrant_busy", busy, 1);

    // out-of-range address at the framebuffer boundary
    do_reset();
    en[0] = 1'b1; lim[0] = 2; last_at[0] = 1; base[0] = 19199;
    step();
    step();
    check("t5_in_we", write_en, 1);
    check("t5_in_addr", write_addr, 19199);
    check("t5_in_clip", clip_err, 0);
    step();
    check("t5_busy", busy, 0);
    check("t5_beats", beat[0], 2);
`ifdef FB_WRITE_CLIP_EN
    check("t5_oob_we", write_en, 0);
    check("t5_oob_clip", clip_err, 1);
`else
    check("t5_oob_we", write_en, 1);
    check("t5_oob_addr", write_addr, 19200);
    check("t5_oob_clip", clip_err, 0);
`endif
    beat[0] = 0; base[0] = 10;
    step();
    step();
    check("t5_next_we", write_en, 1);
    check("t5_next_addr", write_addr, 10);
`ifdef FB_WRITE_CLIP_EN
    check("t5_sticky", clip_err, 1);
`else
    check("t5_sticky", clip_err, 0);
`endif

    // single requester, back-to-back 2-beat bursts
    do_reset();
    en1 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      step();
      check("t6_we", we1, (n % 3) != 1);
      check("t6_gid", g1, 0);
      if ((n % 3) != 1)
        check("t6_addr", wa1, 2 * ((n - 2) / 3) + ((n - 2) % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
